// File: rtl/hex_stream_pkg.sv
// Shared types and constants for the ASCII hex stream reader: FSM states,
// whitespace byte codes and the byte classification result.
package hex_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SKIP  = 3'd1,
    ACCUM = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [7:0] SP = 8'h20;
  localparam logic [7:0] HT = 8'h09;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  typedef enum logic [1:0] {
    WS  = 2'd0,
    HEX = 2'd1,
    BAD = 2'd2
  } byte_class_e;

endpackage

// File: rtl/hex_char_decode.sv
// Classifies one ASCII byte as whitespace, hex digit or illegal, and gives
// the 4-bit digit value (zero unless the byte is a hex digit).
module hex_char_decode
  import hex_stream_pkg::*;
(
  input  logic [7:0]  ch,
  output byte_class_e cls,
  output logic [3:0]  val
);

  always_comb begin
    cls = BAD;
    val = 4'h0;
    if (ch == SP || ch == HT || ch == LF || ch == CR) begin
      cls = WS;
    end else if (ch >= 8'h30 && ch <= 8'h39) begin
      cls = HEX;
      val = ch[3:0];
    end else if ((ch >= 8'h61 && ch <= 8'h66) || (ch >= 8'h41 && ch <= 8'h46)) begin
      // 'a'/'A' have low nibble 1, so +9 maps them onto 10..15
      cls = HEX;
      val = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/hex_stream_reader.sv
// Parses a stream of whitespace-separated ASCII hex tokens into binary words,
// with eof flush, seek restart and sticky character/overflow error flags.
module hex_stream_reader
  import hex_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIGITS = DATA_WIDTH / 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  byte_ready,
  input  logic                  byte_eof,
  input  logic                  seek,
  input  logic                  err_clr,
  output logic                  word_valid,
  output logic [DATA_WIDTH-1:0] word_data,
  input  logic                  word_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  done,
  output logic                  err_char,
  output logic                  err_ovf,
  output state_e                state_dbg
);

  localparam int DCW = $clog2(MAX_DIGITS + 2);
  localparam logic [DCW-1:0] DIG_MAX = DCW'(MAX_DIGITS);
  localparam logic [DCW-1:0] DIG_SAT = DCW'(MAX_DIGITS + 1);

  state_e                state, state_n;
  logic [DATA_WIDTH-1:0] acc, acc_n, word_data_n;
  logic [DCW-1:0]        dig_cnt, dig_cnt_n;
  logic [CNT_WIDTH-1:0]  word_count_n;
  logic                  set_char, set_ovf, byte_hs;
  byte_class_e           cls;
  logic [3:0]            dig_val;

  hex_char_decode u_decode (
    .ch  (byte_data),
    .cls (cls),
    .val (dig_val)
  );

  // Both ports: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and the payload holds while valid.
  assign byte_ready = (state == SKIP) || (state == ACCUM);
  assign byte_hs    = byte_valid && byte_ready;
  assign word_valid = (state == HOLD);
  assign done       = (state == DONE);
  assign state_dbg  = state;

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    dig_cnt_n    = dig_cnt;
    word_data_n  = word_data;
    word_count_n = word_count;
    set_char     = 1'b0;
    set_ovf      = 1'b0;
    unique case (state)
      IDLE: state_n = SKIP;
      SKIP: begin
        if (byte_hs) begin
          if (cls == HEX) begin
            acc_n     = DATA_WIDTH'(dig_val);
            dig_cnt_n = DCW'(1);
            state_n   = ACCUM;
          end else if (cls == BAD) begin
            set_char = 1'b1;
          end
        end else if (byte_eof) begin
          state_n = DONE;
        end
      end
      ACCUM: begin
        if (byte_hs) begin
          if (cls == HEX) begin
            acc_n = (acc << 4) | DATA_WIDTH'(dig_val);
            // Overflow keeps wrapping the value; the count parks at DIG_SAT
            if (dig_cnt >= DIG_MAX) set_ovf = 1'b1;
            if (dig_cnt < DIG_SAT) dig_cnt_n = dig_cnt + DCW'(1);
          end else if (cls == WS) begin
            word_data_n = acc;
            dig_cnt_n   = '0;
            state_n     = HOLD;
          end else begin
            set_char  = 1'b1;
            acc_n     = '0;
            dig_cnt_n = '0;
            state_n   = SKIP;
          end
        end else if (byte_eof) begin
          word_data_n = acc;
          dig_cnt_n   = '0;
          state_n     = HOLD;
        end
      end
      HOLD: begin
        if (word_ready) begin
          word_count_n = word_count + CNT_WIDTH'(1);
          state_n      = SKIP;
        end
      end
      DONE: state_n = DONE;
      default: state_n = IDLE;
    endcase

    // Seek overrides whatever the byte/eof/word logic decided this cycle
    if (seek && state != IDLE) begin
      state_n      = SKIP;
      acc_n        = '0;
      dig_cnt_n    = '0;
      word_count_n = word_count;
      set_char     = 1'b0;
      set_ovf      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      dig_cnt    <= '0;
      word_data  <= '0;
      word_count <= '0;
      err_char   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      dig_cnt    <= dig_cnt_n;
      word_data  <= word_data_n;
      word_count <= word_count_n;
      err_char   <= set_char | (err_char & ~err_clr);
      err_ovf    <= set_ovf | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_hex_stream_reader.sv
// Directed bench for hex_stream_reader: token parsing, eof flush, output
// back-pressure, error flags, overflow and seek restart.
module tb_hex_stream_reader;
  import hex_stream_pkg::*;

  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk, reset, byte_valid, byte_ready, byte_eof, seek, err_clr;
  logic          word_valid, word_ready, done, err_char, err_ovf;
  logic [7:0]    byte_data;
  logic [DW-1:0] word_data;
  logic [CW-1:0] word_count;
  state_e        state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];

  hex_stream_reader #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .byte_eof(byte_eof), .seek(seek), .err_clr(err_clr),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .word_count(word_count), .done(done), .err_char(err_char), .err_ovf(err_ovf),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    reset = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00; byte_eof = 1'b0;
    seek = 1'b0; err_clr = 1'b0; word_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
  endtask

  // Word monitor: records every output handshake
  always @(negedge clk) begin
    if (reset && word_valid && word_ready) got_q.push_back(word_data);
  end

  // Drivers
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!byte_ready) begin
      n_cmp++; n_err++;
      $display("FAIL byte_accept: byte_ready=%b for byte %h, required 1 within 50 cycles", byte_ready, b);
    end else begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL wait_done: done=%b, required 1 within 50 cycles", done);
    end
  endtask

  task automatic wait_words(input int cnt);
    int n = 0;
    while (got_q.size() < cnt && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    n_cmp++;
    if (got_q.size() < cnt) begin
      n_err++;
      $display("FAIL wait_words: got %0d words, required %0d", got_q.size(), cnt);
    end
  endtask

  // Tests
  task automatic test_reset();
    reset = 1'b1;
    byte_valid = 1'b0; byte_data = 8'h00; byte_eof = 1'b0;
    seek = 1'b0; err_clr = 1'b0; word_ready = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({byte_ready, word_valid, done, err_char, err_ovf} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: rdy/vld/done/ec/eo=%b, required 00000",
               {byte_ready, word_valid, done, err_char, err_ovf});
    end
    n_cmp++;
    if (word_data !== '0 || word_count !== '0) begin
      n_err++;
      $display("FAIL reset_regs: word_data=%h word_count=%0d, required 0/0", word_data, word_count);
    end
    n_cmp++;
    if (state_dbg !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d, required %0d", state_dbg, IDLE);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (byte_ready !== 1'b1 || state_dbg !== SKIP) begin
      n_err++;
      $display("FAIL reset_release: byte_ready=%b state=%0d, required 1/%0d", byte_ready, state_dbg, SKIP);
    end
  endtask

  task automatic test_basic();
    do_reset();
    word_ready = 1'b1;
    send_str("1f 2a\n");
    byte_eof = 1'b1;
    wait_done();
    exp_q = '{32'h1F, 32'h2A};
    n_cmp++;
    if (got_q.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL basic_n: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++;
        $display("FAIL basic_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    n_cmp++;
    if (word_count !== 16'd2 || done !== 1'b1 || err_char !== 1'b0 || err_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL basic_status: count=%0d done=%b ec=%b eo=%b, required 2/1/0/0",
               word_count, done, err_char, err_ovf);
    end
    byte_eof = 1'b0;
  endtask

  task automatic test_eof_flush();
    do_reset();
    word_ready = 1'b1;
    send_str("AbC");
    byte_eof = 1'b1;
    wait_done();
    n_cmp++;
    if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0] !== 32'hABC)) begin
      n_err++;
      $display("FAIL flush_word: got %0d words first=%h, required 1 word 00000abc",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx);
    end
    n_cmp++;
    if (word_count !== 16'd1 || byte_ready !== 1'b0) begin
      n_err++;
      $display("FAIL flush_status: count=%0d byte_ready=%b, required 1/0", word_count, byte_ready);
    end
    byte_eof = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    word_ready = 1'b0;
    send_str("7 ");
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (word_valid !== 1'b1 || word_data !== 32'h7 || byte_ready !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: vld=%b data=%h rdy=%b, required 1/00000007/0",
                 c, word_valid, word_data, byte_ready);
      end
      @(posedge clk); #1;
    end
    word_ready = 1'b1;
    @(posedge clk); #1;
    word_ready = 1'b0;
    n_cmp++;
    if (word_valid !== 1'b0 || word_count !== 16'd1 || got_q.size() !== 1) begin
      n_err++;
      $display("FAIL hold_release: vld=%b count=%0d words=%0d, required 0/1/1",
               word_valid, word_count, got_q.size());
    end
  endtask

  task automatic test_bad_char();
    do_reset();
    word_ready = 1'b1;
    send_str("1g");
    n_cmp++;
    if (err_char !== 1'b1) begin
      n_err++;
      $display("FAIL badchar_flag: err_char=%b, required 1", err_char);
    end
    send_str("2 ");
    wait_words(1);
    n_cmp++;
    if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0] !== 32'h2) || err_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL badchar_word: words=%0d first=%h eo=%b, required 1/00000002/0",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx, err_ovf);
    end
    n_cmp++;
    if (err_char !== 1'b1) begin
      n_err++;
      $display("FAIL badchar_sticky: err_char=%b, required 1", err_char);
    end
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    n_cmp++;
    if (err_char !== 1'b0) begin
      n_err++;
      $display("FAIL badchar_clr: err_char=%b, required 0", err_char);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    word_ready = 1'b1;
    send_str("12345678 ");
    wait_words(1);
    n_cmp++;
    if (got_q.size() < 1 || got_q[0] !== 32'h12345678 || err_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_8digit: word=%h eo=%b, required 12345678/0",
               got_q.size() > 0 ? got_q[0] : 32'hx, err_ovf);
    end
    send_str("123456789 ");
    wait_words(2);
    n_cmp++;
    if (got_q.size() < 2 || got_q[1] !== 32'h23456789 || err_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_9digit: word=%h eo=%b, required 23456789/1",
               got_q.size() > 1 ? got_q[1] : 32'hx, err_ovf);
    end
  endtask

  task automatic test_seek();
    do_reset();
    word_ready = 1'b0;
    send_str("55 ");
    n_cmp++;
    if (word_valid !== 1'b1 || word_data !== 32'h55) begin
      n_err++;
      $display("FAIL seek_pre: vld=%b data=%h, required 1/00000055", word_valid, word_data);
    end
    seek = 1'b1;
    @(posedge clk); #1;
    seek = 1'b0;
    n_cmp++;
    if (word_valid !== 1'b0 || word_count !== 16'd0 || byte_ready !== 1'b1) begin
      n_err++;
      $display("FAIL seek_hold: vld=%b count=%0d rdy=%b, required 0/0/1", word_valid, word_count, byte_ready);
    end
    byte_eof = 1'b1;
    wait_done();
    byte_eof = 1'b0;
    seek = 1'b1;
    @(posedge clk); #1;
    seek = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || byte_ready !== 1'b1) begin
      n_err++;
      $display("FAIL seek_done: done=%b rdy=%b, required 0/1", done, byte_ready);
    end
    word_ready = 1'b1;
    send_str("3 ");
    wait_words(1);
    n_cmp++;
    if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0] !== 32'h3) || done !== 1'b0) begin
      n_err++;
      $display("FAIL seek_restart: words=%0d first=%h done=%b, required 1/00000003/0",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 32'hx, done);
    end
    n_cmp++;
    if (word_count !== 16'd1) begin
      n_err++;
      $display("FAIL seek_count: word_count=%0d, required 1", word_count);
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_eof_flush();
    test_backpressure();
    test_bad_char();
    test_overflow();
    test_seek();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
